// File: rtl/d_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_defs
// Shared definitions for the D-stage hazard controller of the 5-stage MIPS
// pipeline: forwarding-source encodings, Tuse/Tnew constants, the in-flight
// writer record and the saturating Tnew decrement used as records age.
// -----------------------------------------------------------------------------
package hazard_defs;

  // Forwarding source for a D-stage operand.
  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_t;

  // Tuse value meaning "operand not read".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles after entering E until the result can be forwarded.
  localparam logic [1:0] TNEW_LUI_JAL = 2'd0;
  localparam logic [1:0] TNEW_ALU     = 2'd1;
  localparam logic [1:0] TNEW_LOAD    = 2'd2;

  // One in-flight writer. addr == 0 means "no write".
  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
  } rec_t;

  // Tnew shrinks by one each stage a writer advances, never below zero.
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/d_hazard_ctrl_src_sel.sv
// -----------------------------------------------------------------------------
// hazard_src_sel
// Per-operand hazard decision. Finds the youngest in-flight writer (E, then M,
// then W) of the operand register and decides whether D must stall and where
// the D-stage comparator should take the value from.
//   r        in   5   operand register index ($0 never matches)
//   tuse     in   2   cycles until the operand is consumed (NO_USE = not read)
//   rec_e    in   rec_t  writer record in E
//   rec_m    in   rec_t  writer record in M
//   rec_w    in   rec_t  writer record in W
//   stall    out  1   operand not ready in time
//   fwd_sel  out  fwd_sel_t  forwarding source (GRF unless youngest match is ready)
// -----------------------------------------------------------------------------
module hazard_src_sel
  import hazard_defs::*;
#(
  parameter logic [1:0] NO_USE = TUSE_NONE
) (
  input  logic [4:0] r,
  input  logic [1:0] tuse,
  input  rec_t       rec_e,
  input  rec_t       rec_m,
  input  rec_t       rec_w,
  output logic       stall,
  output fwd_sel_t   fwd_sel
);

  logic       hit;
  fwd_sel_t   hit_stage;
  logic [1:0] hit_tnew;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the if-chain leaves it holding a value (latch).
    hit       = 1'b0;
    hit_stage = FWD_GRF;
    hit_tnew  = 2'd0;
    // Priority chain: once a younger stage matches, older ones are ignored.
    if (r != 5'd0) begin
      if (rec_e.addr == r) begin
        hit = 1'b1; hit_stage = FWD_E; hit_tnew = rec_e.tnew;
      end else if (rec_m.addr == r) begin
        hit = 1'b1; hit_stage = FWD_M; hit_tnew = rec_m.tnew;
      end else if (rec_w.addr == r) begin
        hit = 1'b1; hit_stage = FWD_W; hit_tnew = rec_w.tnew;
      end
    end
  end

  assign stall   = hit && (tuse != NO_USE) && (hit_tnew > tuse);
  // Select is meaningful even while stalling; a not-yet-ready writer reads GRF.
  assign fwd_sel = (hit && hit_tnew == 2'd0) ? hit_stage : FWD_GRF;

endmodule

// File: rtl/d_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// d_hazard_ctrl
// D-stage hazard controller. Holds a shadow scoreboard of writers in E/M/W,
// produces stall and forwarding selects for the D-stage branch comparator and
// counts stalled cycles (saturating).
//   clk, rst_n               clock (rising edge), async active-low reset
//   D_valid                  D holds a real instruction (0 = bubble)
//   D_rs, D_rt               operand register indices
//   D_tuse_rs, D_tuse_rt     operand Tuse (NO_USE = not read)
//   D_wr_addr, D_tnew        destination and Tnew of the D instruction
//   stall                    hold PC and F/D, insert bubble into E
//   fwd_rs_sel, fwd_rt_sel   comparator sources: 0=GRF 1=E 2=M 3=W
//   stall_cnt                saturating count of stalled cycles
// -----------------------------------------------------------------------------
module d_hazard_ctrl
  import hazard_defs::*;
#(
  parameter int         CNT_W  = 16,
  parameter logic [1:0] NO_USE = TUSE_NONE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D_valid,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic [4:0]       D_wr_addr,
  input  logic [1:0]       D_tnew,
  output logic             stall,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  rec_t     rec_e, rec_m, rec_w;
  logic     stall_rs, stall_rt;
  fwd_sel_t sel_rs, sel_rt;

  hazard_src_sel #(.NO_USE(NO_USE)) u_sel_rs (
    .r      (D_rs),
    .tuse   (D_tuse_rs),
    .rec_e  (rec_e),
    .rec_m  (rec_m),
    .rec_w  (rec_w),
    .stall  (stall_rs),
    .fwd_sel(sel_rs)
  );

  hazard_src_sel #(.NO_USE(NO_USE)) u_sel_rt (
    .r      (D_rt),
    .tuse   (D_tuse_rt),
    .rec_e  (rec_e),
    .rec_m  (rec_m),
    .rec_w  (rec_w),
    .stall  (stall_rt),
    .fwd_sel(sel_rt)
  );

  // A bubble in D never stalls.
  assign stall      = D_valid && (stall_rs || stall_rt);
  assign fwd_rs_sel = sel_rs;
  assign fwd_rt_sel = sel_rt;

  // NOTE: the records are a handful of flops that drive the stall logic
  // directly, so they are reset; stale addresses would cause false stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_e <= '0;
      rec_m <= '0;
      rec_w <= '0;
    end else begin
      // NOTE: non-blocking assignments let the three records shift in one
      // edge without the order of statements mattering.
      rec_e <= (stall || !D_valid) ? rec_t'('0) : rec_t'{addr: D_wr_addr, tnew: D_tnew};
      rec_m <= rec_t'{addr: rec_e.addr, tnew: sat_dec(rec_e.tnew)};
      rec_w <= rec_t'{addr: rec_m.addr, tnew: sat_dec(rec_m.tnew)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
